// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - sequencer between EX and the signed/unsigned AXI-stream divider IPs
//
// Holds one divide at a time: latches operands, drives the dividend and divisor
// channels of the selected IP independently, waits for dout and keeps
// quotient/remainder until EX acknowledges. A flush after the IP has taken any
// operand moves to DRAIN, which finishes the owed handshake and swallows the
// result so the IP never falls out of step with the pipeline.
//
// Optional feature macro: DIV_ZERO_FAST_EN
//   defined   : divisor 0 skips the IP; quotient all-ones, remainder = dividend
//   undefined : divisor 0 goes to the IP like any other operand
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   req_valid/req_signed/req_src1/2   request from EX (dividend src1, divisor src2)
//   req_ready                         idle, request may be accepted
//   flush                             discard current op
//   res_ack                           EX consumed the result
//   done/quotient/remainder           registered result, held until res_ack
//   busy                              not idle
//   cyc_cnt                           cycles from issue to done, saturating
//   ip_dividend/ip_divisor            latched operands, shared by both IPs
//   {s,u}div_dvd_*/{s,u}div_dvs_*     operand channel handshakes
//   {s,u}div_dout_tvalid/tdata        result channel, tdata = {quotient, remainder}

module div_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  input  logic                req_signed,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  output logic                req_ready,
  input  logic                flush,
  input  logic                res_ack,
  output logic                done,
  output logic [DATA_W-1:0]   quotient,
  output logic [DATA_W-1:0]   remainder,
  output logic                busy,
  output logic [CNT_W-1:0]    cyc_cnt,
  output logic [DATA_W-1:0]   ip_dividend,
  output logic [DATA_W-1:0]   ip_divisor,
  output logic                sdiv_dvd_tvalid,
  output logic                sdiv_dvs_tvalid,
  output logic                udiv_dvd_tvalid,
  output logic                udiv_dvs_tvalid,
  input  logic                sdiv_dvd_tready,
  input  logic                sdiv_dvs_tready,
  input  logic                udiv_dvd_tready,
  input  logic                udiv_dvs_tready,
  input  logic                sdiv_dout_tvalid,
  input  logic [2*DATA_W-1:0] sdiv_dout_tdata,
  input  logic                udiv_dout_tvalid,
  input  logic [2*DATA_W-1:0] udiv_dout_tdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic sel_signed;
  // A pend flag is set while its channel still owes a handshake to the IP.
  logic dvd_pend, dvs_pend;
  logic dvd_pend_nxt, dvs_pend_nxt;

  logic                dvd_hs, dvs_hs;
  logic                dvd_left, dvs_left;
  logic                dout_v;
  logic [2*DATA_W-1:0] dout_d;
  logic                latch_req, cap_res, fast_zero;

  // Only the IP picked at accept time is looked at; the other one is ignored.
  always_comb begin
    dvd_hs   = dvd_pend & (sel_signed ? sdiv_dvd_tready : udiv_dvd_tready);
    dvs_hs   = dvs_pend & (sel_signed ? sdiv_dvs_tready : udiv_dvs_tready);
    dvd_left = dvd_pend & ~dvd_hs;
    dvs_left = dvs_pend & ~dvs_hs;
    dout_v   = sel_signed ? sdiv_dout_tvalid : udiv_dout_tvalid;
    dout_d   = sel_signed ? sdiv_dout_tdata  : udiv_dout_tdata;
  end

  always_comb begin
    state_nxt    = state;
    dvd_pend_nxt = dvd_left;
    dvs_pend_nxt = dvs_left;
    latch_req    = 1'b0;
    cap_res      = 1'b0;
    fast_zero    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          latch_req    = 1'b1;
          state_nxt    = S_ISSUE;
          dvd_pend_nxt = 1'b1;
          dvs_pend_nxt = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (req_src2 == '0) begin
            dvd_pend_nxt = 1'b0;
            dvs_pend_nxt = 1'b0;
          end
`endif
        end
      end
      S_ISSUE: begin
`ifdef DIV_ZERO_FAST_EN
        if (ip_divisor == '0) begin
          if (flush) begin
            state_nxt = S_IDLE;
          end else begin
            fast_zero = 1'b1;
            state_nxt = S_DONE;
          end
        end else
`endif
        if (flush) begin
          // Once the IP has taken either operand it will produce a result,
          // so the other operand must still be delivered and the result drained.
          if (dvd_left && dvs_left && dvd_pend && dvs_pend) begin
            state_nxt    = S_IDLE;
            dvd_pend_nxt = 1'b0;
            dvs_pend_nxt = 1'b0;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else if (!dvd_left && !dvs_left) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dout_v) begin
          if (flush) begin
            state_nxt = S_IDLE;
          end else begin
            cap_res   = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush || res_ack) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (dout_v) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt    = S_IDLE;
        dvd_pend_nxt = 1'b0;
        dvs_pend_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      sel_signed  <= 1'b0;
      dvd_pend    <= 1'b0;
      dvs_pend    <= 1'b0;
      ip_dividend <= '0;
      ip_divisor  <= '0;
      quotient    <= '0;
      remainder   <= '0;
      cyc_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      dvd_pend <= dvd_pend_nxt;
      dvs_pend <= dvs_pend_nxt;
      if (latch_req) begin
        ip_dividend <= req_src1;
        ip_divisor  <= req_src2;
        sel_signed  <= req_signed;
        cyc_cnt     <= '0;
      end else if ((state == S_ISSUE || state == S_WAIT) && cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (cap_res) begin
        quotient  <= dout_d[2*DATA_W-1:DATA_W];
        remainder <= dout_d[DATA_W-1:0];
      end else if (fast_zero) begin
        quotient  <= '1;
        remainder <= ip_dividend;
      end
    end
  end

  always_comb begin
    req_ready       = (state == S_IDLE);
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
    sdiv_dvd_tvalid = dvd_pend & sel_signed;
    sdiv_dvs_tvalid = dvs_pend & sel_signed;
    udiv_dvd_tvalid = dvd_pend & ~sel_signed;
    udiv_dvs_tvalid = dvs_pend & ~sel_signed;
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - scoreboard bench for div_seq_ctrl with behavioural divider IPs
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req_valid = 1'b0, req_signed = 1'b0;
  logic [W-1:0] req_src1 = '0, req_src2 = '0;
  logic         req_ready, flush = 1'b0, res_ack = 1'b0;
  logic         done, busy;
  logic [W-1:0] quotient, remainder, ip_dividend, ip_divisor;
  logic [7:0]   cyc_cnt;
  logic         sdiv_dvd_tvalid, sdiv_dvs_tvalid, udiv_dvd_tvalid, udiv_dvs_tvalid;
  logic         sdiv_dvd_tready, sdiv_dvs_tready, udiv_dvd_tready, udiv_dvs_tready;
  logic         sdiv_dout_tvalid, udiv_dout_tvalid;
  logic [2*W-1:0] sdiv_dout_tdata, udiv_dout_tdata;

  always #5 clk = ~clk;

  div_seq_ctrl #(.DATA_W(W), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_signed(req_signed),
    .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready),
    .flush(flush), .res_ack(res_ack),
    .done(done), .quotient(quotient), .remainder(remainder),
    .busy(busy), .cyc_cnt(cyc_cnt),
    .ip_dividend(ip_dividend), .ip_divisor(ip_divisor),
    .sdiv_dvd_tvalid(sdiv_dvd_tvalid), .sdiv_dvs_tvalid(sdiv_dvs_tvalid),
    .udiv_dvd_tvalid(udiv_dvd_tvalid), .udiv_dvs_tvalid(udiv_dvs_tvalid),
    .sdiv_dvd_tready(sdiv_dvd_tready), .sdiv_dvs_tready(sdiv_dvs_tready),
    .udiv_dvd_tready(udiv_dvd_tready), .udiv_dvs_tready(udiv_dvs_tready),
    .sdiv_dout_tvalid(sdiv_dout_tvalid), .sdiv_dout_tdata(sdiv_dout_tdata),
    .udiv_dout_tvalid(udiv_dout_tvalid), .udiv_dout_tdata(udiv_dout_tdata)
  );

  // Reference division: C-style truncation; divide by zero gives all-ones / dividend.
  function automatic logic [2*W-1:0] ref_div(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1; r = a;
    end else if (sg) begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  // Divider IP models, index 1 = signed, 0 = unsigned.
  bit   rdy_force = 1'b1;
  bit   rf_dvd[2] = '{1'b1, 1'b1};
  bit   rf_dvs[2] = '{1'b1, 1'b1};
  bit   rnd_dvd[2], rnd_dvs[2];
  int   ip_lat = 2;
  logic ip_dvd_v[2], ip_dvs_v[2];
  logic ip_got_dvd[2], ip_got_dvs[2], ip_run[2], ip_out_v[2];
  logic [W-1:0] ip_a[2], ip_b[2];
  logic [2*W-1:0] ip_out_d[2];
  int   ip_cnt[2];

  assign ip_dvd_v[1] = sdiv_dvd_tvalid;
  assign ip_dvs_v[1] = sdiv_dvs_tvalid;
  assign ip_dvd_v[0] = udiv_dvd_tvalid;
  assign ip_dvs_v[0] = udiv_dvs_tvalid;
  assign sdiv_dvd_tready = rdy_force ? rf_dvd[1] : rnd_dvd[1];
  assign sdiv_dvs_tready = rdy_force ? rf_dvs[1] : rnd_dvs[1];
  assign udiv_dvd_tready = rdy_force ? rf_dvd[0] : rnd_dvd[0];
  assign udiv_dvs_tready = rdy_force ? rf_dvs[0] : rnd_dvs[0];
  assign sdiv_dout_tvalid = ip_out_v[1];
  assign sdiv_dout_tdata  = ip_out_d[1];
  assign udiv_dout_tvalid = ip_out_v[0];
  assign udiv_dout_tdata  = ip_out_d[0];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rnd_dvd[k] <= 1'($urandom_range(0, 1));
      rnd_dvs[k] <= 1'($urandom_range(0, 1));
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        ip_got_dvd[k] <= 1'b0; ip_got_dvs[k] <= 1'b0; ip_run[k] <= 1'b0;
        ip_out_v[k] <= 1'b0; ip_out_d[k] <= '0; ip_a[k] <= '0; ip_b[k] <= '0; ip_cnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic hs_a, hs_b;
        logic [W-1:0] a_now, b_now;
        hs_a = ip_dvd_v[k] && (k == 1 ? sdiv_dvd_tready : udiv_dvd_tready);
        hs_b = ip_dvs_v[k] && (k == 1 ? sdiv_dvs_tready : udiv_dvs_tready);
        a_now = hs_a ? ip_dividend : ip_a[k];
        b_now = hs_b ? ip_divisor  : ip_b[k];
        ip_out_v[k] <= 1'b0;
        if (hs_a) begin ip_got_dvd[k] <= 1'b1; ip_a[k] <= ip_dividend; end
        if (hs_b) begin ip_got_dvs[k] <= 1'b1; ip_b[k] <= ip_divisor; end
        if (ip_run[k]) begin
          if (ip_cnt[k] == 0) begin
            ip_out_v[k] <= 1'b1;
            ip_out_d[k] <= ref_div(k == 1, ip_a[k], ip_b[k]);
            ip_run[k]   <= 1'b0;
          end else begin
            ip_cnt[k] <= ip_cnt[k] - 1;
          end
        end else if ((ip_got_dvd[k] || hs_a) && (ip_got_dvs[k] || hs_b)) begin
          ip_run[k] <= 1'b1; ip_cnt[k] <= ip_lat;
          ip_a[k] <= a_now; ip_b[k] <= b_now;
          ip_got_dvd[k] <= 1'b0; ip_got_dvs[k] <= 1'b0;
        end
      end
    end
  end

  int checks = 0, passes = 0;
  logic [2*W-1:0] exp_q[$];
  int n_sdvd, n_sdvs, n_udvd, n_udvs, cyc;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic fail_timeout(input string n);
    checks++;
    $display("FAIL %s: got timeout expected event", n);
  endtask

  // Pops an expected result on every rising edge of done.
  task automatic monitor();
    logic prev;
    logic [2*W-1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) prev = 1'b0;
      else begin
        if (done && !prev) begin
          if (exp_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("quotient", 64'(quotient), 64'(e[2*W-1:W]));
            chk("remainder", 64'(remainder), 64'(e[W-1:0]));
          end
        end
        prev = done;
      end
    end
  endtask

  // Drives one request; returns at the negedge of the first ISSUE cycle.
  task automatic issue(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge clk);
    req_valid = 1'b1; req_signed = sg; req_src1 = a; req_src2 = b;
    if (push) exp_q.push_back(ref_div(sg, a, b));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int rel_cyc);
    n_sdvd = 0; n_sdvs = 0; n_udvd = 0; n_udvs = 0; cyc = 1;
    forever begin
      if (cyc == rel_cyc) rf_dvs[0] = 1'b1;
      n_sdvd += int'(sdiv_dvd_tvalid); n_sdvs += int'(sdiv_dvs_tvalid);
      n_udvd += int'(udiv_dvd_tvalid); n_udvs += int'(udiv_dvs_tvalid);
      if (done) break;
      if (cyc > 300) begin fail_timeout("done_wait"); break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic ack(input int hold);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("done_held", 64'(done), 64'd1);
    end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk("done_drop", 64'(done), 64'd0);
  endtask

  task automatic wait_idle(input string n, output bit saw_done);
    saw_done = 1'b0;
    for (int i = 0; i < 60 && !req_ready; i++) begin
      @(negedge clk);
      saw_done |= done;
    end
    chk(n, 64'(req_ready), 64'd1);
  endtask

  initial begin
    bit saw;
    fork monitor(); join_none

    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_tvalids", {60'd0, sdiv_dvd_tvalid, sdiv_dvs_tvalid, udiv_dvd_tvalid, udiv_dvs_tvalid}, 64'd0);
    chk("rst_cnt_q", {cyc_cnt, quotient}, 64'd0);
    @(negedge clk); resetn = 1'b1;

    // signed -7/2, IP latency 10, result held 5 cycles
    ip_lat = 10;
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done(0);
    chk("t2_q", 64'(quotient), 64'hFFFFFFFD);
    ack(5);

    // reset during WAIT
    ip_lat = 20;
    issue(1'b0, 32'd1000, 32'd10, 1'b1);
    repeat (3) @(negedge clk);
    chk("t1_busy_pre", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("t1_outs", {done, busy, sdiv_dvd_tvalid, sdiv_dvs_tvalid, udiv_dvd_tvalid, udiv_dvs_tvalid}, 64'd0);
    chk("t1_regs", {quotient, remainder}, 64'd0);
    chk("t1_ops_cnt", {ip_dividend, ip_divisor} | 64'(cyc_cnt), 64'd0);
    chk("t1_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    @(negedge clk); resetn = 1'b1;
    ip_lat = 2;
    issue(1'b0, 32'd1000, 32'd10, 1'b1);
    wait_done(0);
    ack(1);

    // unsigned 100/7, divisor channel stalled 3 cycles
    rf_dvs[0] = 1'b0;
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    wait_done(4);
    chk("t3_dvd_cycles", 64'(n_udvd), 64'd1);
    chk("t3_dvs_cycles", 64'(n_udvs), 64'd4);
    chk("t3_sdiv_idle", 64'(n_sdvd + n_sdvs), 64'd0);
    ack(2);

    // flush in WAIT -> DRAIN, then 9/3
    ip_lat = 6;
    issue(1'b0, 32'd50, 32'd5, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_drain_ready", 64'(req_ready), 64'd0);
    chk("t4_drain_busy", 64'(busy), 64'd1);
    flush = 1'b1;                        // further flush in DRAIN is ignored
    @(negedge clk);
    flush = 1'b0;
    wait_idle("t4_idle", saw);
    chk("t4_no_done", 64'(saw), 64'd0);
    ip_lat = 1;
    issue(1'b0, 32'd9, 32'd3, 1'b1);
    wait_done(0);
    ack(1);

    // flush in ISSUE with dividend taken, divisor not
    rf_dvs[0] = 1'b0;
    issue(1'b0, 32'd77, 32'd4, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("t5_dvs_held", 64'(udiv_dvs_tvalid), 64'd1);
    chk("t5_dvd_dropped", 64'(udiv_dvd_tvalid), 64'd0);
    chk("t5_drain_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("t5_dvs_held2", 64'(udiv_dvs_tvalid), 64'd1);
    rf_dvs[0] = 1'b1;
    wait_idle("t5_idle", saw);
    chk("t5_no_done", 64'(saw), 64'd0);

    // flush in ISSUE with nothing taken
    rf_dvd[1] = 1'b0; rf_dvs[1] = 1'b0;
    issue(1'b1, 32'd77, 32'd4, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5b_idle", 64'(req_ready), 64'd1);
    chk("t5b_tvalids", {62'd0, sdiv_dvd_tvalid, sdiv_dvs_tvalid}, 64'd0);
    rf_dvd[1] = 1'b1; rf_dvs[1] = 1'b1;

    // divide by zero
    ip_lat = 3;
    issue(1'b0, 32'd5, 32'd0, 1'b1);
    wait_done(0);
`ifdef DIV_ZERO_FAST_EN
    chk("t6_latency", 64'(cyc), 64'd2);
    chk("t6_no_tvalid", 64'(n_udvd + n_udvs + n_sdvd + n_sdvs), 64'd0);
    chk("t6_cyc_cnt", 64'(cyc_cnt), 64'd1);
`else
    chk("t6_tvalid_issued", 64'(n_udvd > 0 && n_udvs > 0), 64'd1);
`endif
    ack(1);

    // random operands, random tready, random IP latency and ack delay
    rdy_force = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bit sg;
      logic [W-1:0] a, b;
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (n % 3 == 0) ? W'($urandom_range(1, 20)) : $urandom;
      if (n % 5 == 0) b = -b;
      if (b == '0) b = 32'd1;
      if (sg && a == 32'h80000000 && b == '1) b = 32'd3;
      ip_lat = $urandom_range(0, 4);
      issue(sg, a, b, 1'b1);
      wait_done(0);
      ack($urandom_range(1, 3));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
